// File: rtl/seq_mult8x8_ctrl_if.sv
// Request/result handshake bundle for seq_mult8x8_ctrl.
// master = requester/consumer side, slave = multiplier side.
interface seq_mult8x8_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_prod;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag, busy
  );
endinterface

// File: rtl/seq_mult8x8_ctrl.sv
// Sequential 8x8 unsigned multiplier built from one shared mult4x4,
// one nibble pair per cycle, shifted and summed into a 16-bit acc.
module seq_mult8x8_ctrl #(
  parameter int TAG_W = 4
) (
  input logic nvdla_core_clk,
  input logic nvdla_core_rstn,
  seq_mult8x8_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [15:0]      acc_q, acc_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [3:0]  nib_a, nib_b;
  logic [7:0]  m_out;
  logic [15:0] m_sh;
  logic        idle, done;
  logic        hs_in, hs_out;

  assign idle   = (state_q == IDLE);
  assign done   = (state_q == DONE);
  assign hs_in  = io.in_valid && io.in_ready;
  assign hs_out = done && io.out_ready;

  // Ready/valid come only from registered state (and reset).
  assign io.in_ready  = nvdla_core_rstn && idle;
  assign io.out_valid = done;
  assign io.busy      = !idle;
  assign io.out_prod  = done ? acc_q : 16'h0000;
  assign io.out_tag   = done ? tag_q : '0;

  // Pick the operand nibble pair for the current step.
  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    unique case (step_q)
      2'd0: begin nib_a = a_q[3:0]; nib_b = b_q[3:0]; end
      2'd1: begin nib_a = a_q[7:4]; nib_b = b_q[3:0]; end
      2'd2: begin nib_a = a_q[3:0]; nib_b = b_q[7:4]; end
      2'd3: begin nib_a = a_q[7:4]; nib_b = b_q[7:4]; end
    endcase
  end

  mult4x4 u_mult (
    .a (nib_a),
    .b (nib_b),
    .p (m_out)
  );

  // Align the partial product by the nibble weight of this step.
  always_comb begin
    m_sh = {8'h00, m_out};
    unique case (step_q)
      2'd0: m_sh = {8'h00, m_out};
      2'd1: m_sh = {4'h0, m_out, 4'h0};
      2'd2: m_sh = {4'h0, m_out, 4'h0};
      2'd3: m_sh = {m_out, 8'h00};
    endcase
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    unique case (state_q)
      IDLE: begin
        if (hs_in) begin
          a_d     = io.in_a;
          b_d     = io.in_b;
          tag_d   = io.in_tag;
          acc_d   = 16'h0000;
          step_d  = 2'd0;
          state_d = STEP;
        end
      end
      STEP: begin
        acc_d  = acc_q + m_sh;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (hs_out) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      acc_q   <= 16'h0000;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// 4x4 nibble multiplier; this build is exact.
// Approximate variants swap in here with the same ports.
module mult4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'h0, a} * {4'h0, b};
endmodule

// File: doc/seq_mult8x8_ctrl.md
# seq_mult8x8_ctrl

Multi-cycle controller that computes an 8x8 unsigned product by time-sharing a single `mult4x4` approximate 4x4 multiplier over four steps. Each step multiplies one operand-nibble pair, shifts the result and adds it into a 16-bit accumulator. Operands enter and results leave through valid/ready handshakes. The block sits in the CMAC approximate-MAC area as the area-reduced alternative to a fully parallel 8x8 array.

## Interface
Parameters:
- `TAG_W`, default 4: width of the opaque tag carried from request to result.

Ports:
- `nvdla_core_clk`  in  1  sole clock; all state updates on its rising edge.
- `nvdla_core_rstn`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_a`  in  8  multiplicand, unsigned.
- `in_b`  in  8  multiplier, unsigned.
- `in_tag`  in  TAG_W  request tag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_prod`  out  16  product.
- `out_tag`  out  TAG_W  tag of the request that produced `out_prod`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, STEP, DONE. There is a 2-bit step counter `step`.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch a, b and tag into registers, clear acc to 0, set step=0, go to STEP.
- STEP:
  - One shared `mult4x4` instance takes its inputs from the latched operands, selected by `step`:
    - step 0: a[3:0]×b[3:0], shift 0
    - step 1: a[7:4]×b[3:0], shift 4
    - step 2: a[3:0]×b[7:4], shift 4
    - step 3: a[7:4]×b[7:4], shift 8
  - Each cycle: acc ← acc + ({8'b0, mult_out} << shift), truncated to 16 bits. The largest step sum fits in 16 bits, so no overflow.
  - step increments each cycle. After the step-3 accumulate, go to DONE.
- DONE:
  - `out_valid`=1, `out_prod`=acc, `out_tag`=latched tag.
  - Hold all three stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- The arithmetic result is exactly the shifted sum of the four `mult4x4` outputs. It equals the exact product whenever `mult4x4` is exact for all four nibble pairs. The controller adds no error of its own.
- Requests do not overlap: `in_ready`=0 in STEP and DONE. Input values presented while `in_ready`=0 are ignored.
- Reset values (`nvdla_core_rstn`=0 at a clock edge):
  - state=IDLE, step=0, acc=0, latched a/b/tag=0.
  - `in_ready`=1 once reset is deasserted; during reset `in_ready` is driven 0.
  - `out_valid`=0, `out_prod`=0, `out_tag`=0, `busy`=0.
- Reset mid-operation: any in-flight request is discarded with no output. The first cycle after reset is IDLE.

## Timing
- Cycle 0: request handshake.
- Cycles 1–4: STEP (steps 0–3).
- Cycle 5: `out_valid`=1 with the final product (latency 5).
- If `out_ready` is high in cycle 5, the block is in IDLE in cycle 6 and can accept there. Maximum throughput is therefore 1 result per 6 cycles.
- `out_ready` low stalls in DONE indefinitely. Outputs stay stable and `in_ready` stays 0.
- `in_ready` and `out_valid` are decoded from registered state; neither depends combinationally on `in_valid` or `out_ready`.
- `out_prod` is registered (acc). The `mult4x4` output feeds only the accumulator adder, giving a single-cycle path: operand mux → mult4x4 → adder → acc.

## Test plan
- Reset: hold `nvdla_core_rstn`=0 for 3 cycles with `in_valid`=1 → `out_valid`=0, `busy`=0, `out_prod`=0. The cycle after release: `in_ready`=1 and no request has been accepted during reset.
- Basic product: a=0x12, b=0x21, tag=0x5, `out_ready`=1 → `out_valid` exactly 5 cycles after accept, `out_prod`=0x0252, `out_tag`=0x5. `in_ready` returns 1 in cycle 6.
- Model match: a=0xFF, b=0xFF, then 200 random pairs → each `out_prod` equals the sum of four shifted `mult4x4` outputs computed by a bench model. Zero operands (a=0x00, b=0xAB) give 0x0000.
- Backpressure: a=0x0A, b=0x0B, hold `out_ready`=0 for 10 cycles → `out_prod`=0x006E stays stable. Toggling `in_valid` during the stall is ignored. Result is released on the first `out_ready`=1.
- Back-to-back: `in_valid` held high with two queued requests (0x03×0x04, then 0x10×0x10) → results 0x000C then 0x0100. Accepts are 6 cycles apart, tags are in order, nothing is dropped or duplicated.
- Reset mid-op: assert reset in cycle 3 after accept → no `out_valid`. After release, a new request 0x02×0x02 yields 0x0004 with latency 5.
